imem_banked: RTL and testbench
==============================

Name: imem_banked

Overview:
- Parametrised successor to the fixed combinational instruction ROM.
- Holds BANKS independent program images, each DEPTH words of IW bits, in writable storage.
- Registered fetch port: one-cycle latency, valid flag, stall hold, out-of-range detection.
- Load port programs words at run time; a clear engine zero-fills a whole bank (word 0 is the "done" encoding).
- Sits between the PC/fetch stage and decode.

Parameters:
- IW, 9, instruction word width in bits.
- PW, 8, PC / address width in bits.
- DEPTH, 256, words per bank; must be ≤ 2**PW.
- BANKS, 4, number of program banks; BW = max(1, clog2(BANKS)).

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  request a fetch of PC from bank_sel this cycle.
- PC  in  PW  fetch address.
- bank_sel  in  BW  bank to fetch from.
- stall  in  1  hold iptr/iptr_valid/addr_err at current values.
- iptr  out  IW  fetched instruction.
- iptr_valid  out  1  iptr holds the result of a fetch accepted last cycle.
- addr_err  out  1  last accepted fetch had PC ≥ DEPTH or bank_sel ≥ BANKS.
- ld_en  in  1  write ld_data to ld_bank/ld_addr.
- ld_bank  in  BW  load bank.
- ld_addr  in  PW  load address.
- ld_data  in  IW  load word.
- clr_req  in  1  start zero-fill of clr_bank.
- clr_bank  in  BW  bank to clear.
- busy  out  1  clear engine active; fetch and load are ignored.

Behaviour:
- Reset (sync, active-high):
  - iptr=0, iptr_valid=0, addr_err=0, busy=0, FSM=READY, clear counter=0.
  - Storage contents are not reset.
  - Reset wins over every other input in the same cycle.
- FSM states:
  - READY: fetch and load serviced.
  - CLEAR: writes 0 to address clr_cnt of the latched bank every cycle.
- Transitions:
  - READY→CLEAR when clr_req=1 and clr_bank < BANKS. Latches the bank, clr_cnt=0, busy=1 from the next cycle.
  - A clr_req with an invalid bank is ignored.
  - CLEAR→READY after the write at clr_cnt=DEPTH-1. busy=0 the following cycle; the clear takes exactly DEPTH cycles.
  - clr_req while in CLEAR is ignored.
- Reset during CLEAR aborts the clear. Words already written stay 0; the rest are untouched.
- Fetch is accepted when READY, fetch_req=1 and stall=0:
  - Next cycle iptr_valid=1.
  - If in range: iptr=mem[bank_sel][PC], addr_err=0.
  - Otherwise: iptr=0 (done), addr_err=1.
- Cycle with no accepted fetch and stall=0: iptr_valid=0; iptr and addr_err retain their values.
- stall=1 holds iptr, iptr_valid and addr_err unchanged, and fetch_req is not accepted.
- Fetch requests while busy=1 are dropped: iptr_valid=0 next cycle unless stall=1.
- Load: in READY with ld_en=1, the write takes effect at the edge.
  - Out-of-range ld_addr or ld_bank: write dropped silently.
  - Loads while busy are dropped.
- Simultaneous fetch and load to the same bank/address: write-first. iptr returns ld_data.
- Simultaneous clr_req and ld_en in READY: the load is performed that cycle, then the clear starts. The clear overwrites that word later only if it is in the cleared bank.
- Simultaneous clr_req and fetch_req in READY: the fetch is accepted and the clear starts.
- Width rules:
  - PC and ld_addr compare against DEPTH as unsigned values at PW+1 bits.
  - clr_cnt is clog2(DEPTH)+1 bits wide, so DEPTH=2**PW needs no wrap special case.
- Reads are synchronous (one-cycle latency), so the storage maps to block RAM.

Test Plan:
- Reset, then load bank0 addr0..3 = 'b000_000_001, 'b000_000_010, 'b000_000_011, 'b000_000_100. Fetch PC=0..3 back-to-back → iptr equals those words one cycle later each, iptr_valid=1 every cycle, addr_err=0.
- Load bank1 addr5=9'h1AB and bank0 addr5=9'h055. Fetch PC=5 with bank_sel=1, then bank_sel=0 → 9'h1AB then 9'h055 (banks independent).
- DEPTH=64: fetch PC=64 → iptr=0, addr_err=1, iptr_valid=1. A load to addr 70 does not alter any word.
- Fetch PC=2, then assert stall for 3 cycles with fetch_req=1 and PC=3 → iptr holds word 2 and iptr_valid=1 throughout. On release, word 3 appears one cycle later.
- Same-cycle ld_en and fetch_req to bank2 addr9, data 9'h0F0 → iptr=9'h0F0 next cycle.
- Clear bank0 with DEPTH=256:
  - busy=1 for exactly 256 cycles; fetches during it give iptr_valid=0.
  - Afterwards, fetches of PC=0..3 return 0.
  - Repeat with Reset asserted after 10 clear cycles → busy=0 next cycle, addr0..9=0, addr10 still holds its prior value.

Source files
------------

// File: rtl/imem_banked_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_banked_if
//  Description : Fetch / load / clear bus between the fetch stage and the
//                banked instruction memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_banked_if #(
    parameter int IW = 9,
    parameter int PW = 8,
    parameter int BW = 2
);
    // fetch side
    logic          fetch_req;
    logic [PW-1:0] pc;
    logic [BW-1:0] bank_sel;
    logic          stall;
    logic [IW-1:0] iptr;
    logic          iptr_valid;
    logic          addr_err;
    // program load side
    logic          ld_en;
    logic [BW-1:0] ld_bank;
    logic [PW-1:0] ld_addr;
    logic [IW-1:0] ld_data;
    // bank clear side
    logic          clr_req;
    logic [BW-1:0] clr_bank;
    logic          busy;

    modport master (
        output fetch_req, pc, bank_sel, stall,
        output ld_en, ld_bank, ld_addr, ld_data,
        output clr_req, clr_bank,
        input  iptr, iptr_valid, addr_err, busy
    );

    modport slave (
        input  fetch_req, pc, bank_sel, stall,
        input  ld_en, ld_bank, ld_addr, ld_data,
        input  clr_req, clr_bank,
        output iptr, iptr_valid, addr_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/imem_banked.sv
`default_nettype none
// ============================================================================
//  Module      : imem_banked
//  Description : BANKS writable program images of DEPTH x IW words with a
//                registered fetch port, run-time load port and a bank
//                zero-fill engine.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_banked #(
    parameter int IW    = 9,
    parameter int PW    = 8,
    parameter int DEPTH = 256,
    parameter int BANKS = 4
) (
    input wire clk,
    input wire rst,
    imem_banked_if.slave bus
);
    localparam int c_BW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam int c_NW = BANKS * DEPTH;
    localparam int c_LW = (c_NW > 1) ? $clog2(c_NW) : 1;

    typedef enum logic [0:0] {
        S_READY = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_clr_cnt;
    logic [c_CW-1:0]   w_clr_cnt_nxt;
    logic [c_BW-1:0]   r_clr_bank;
    logic [c_BW-1:0]   w_clr_bank_nxt;

    logic [IW-1:0]     r_mem [c_NW];
    logic [IW-1:0]     r_iptr;
    logic              r_iptr_valid;
    logic              r_addr_err;

    logic              w_we;
    logic [c_LW-1:0]   w_waddr;
    logic [IW-1:0]     w_wdata;

    logic              w_fetch_acc;
    logic              w_fetch_in_range;
    logic              w_ld_ok;
    logic              w_clr_bank_ok;
    logic [c_LW-1:0]   w_raddr;
    logic [c_LW-1:0]   w_ld_flat;
    logic [c_LW-1:0]   w_clr_flat;
    logic [IW-1:0]     w_rdata;

    // Range checks are done one bit wider so DEPTH = 2**PW and
    // BANKS = 2**BW compare correctly.
    assign w_fetch_in_range = ({1'b0, bus.pc} < (PW + 1)'(DEPTH)) &&
                              ({1'b0, bus.bank_sel} < (c_BW + 1)'(BANKS));
    assign w_ld_ok          = bus.ld_en &&
                              ({1'b0, bus.ld_addr} < (PW + 1)'(DEPTH)) &&
                              ({1'b0, bus.ld_bank} < (c_BW + 1)'(BANKS));
    assign w_clr_bank_ok    = ({1'b0, bus.clr_bank} < (c_BW + 1)'(BANKS));

    assign w_fetch_acc = (r_state == S_READY) && bus.fetch_req && !bus.stall;

    // All banks live in one flat array so the storage maps to a single RAM.
    assign w_raddr    = c_LW'(bus.bank_sel) * c_LW'(DEPTH) + c_LW'(bus.pc);
    assign w_ld_flat  = c_LW'(bus.ld_bank) * c_LW'(DEPTH) + c_LW'(bus.ld_addr);
    assign w_clr_flat = c_LW'(r_clr_bank) * c_LW'(DEPTH) + c_LW'(r_clr_cnt);

    // Write-first: a same-cycle load to the fetched word is forwarded.
    assign w_rdata = (w_we && (w_waddr == w_raddr)) ? w_wdata : r_mem[w_raddr];

    // State register for the clear engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_READY;
            r_clr_cnt  <= '0;
            r_clr_bank <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_clr_bank <= w_clr_bank_nxt;
        end
    end

    // Next state and the single storage write port (load in READY, zero in CLEAR).
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_clr_bank_nxt = r_clr_bank;
        w_we           = 1'b0;
        w_waddr        = '0;
        w_wdata        = '0;
        case (r_state)
            S_READY: begin
                if (w_ld_ok) begin
                    w_we    = 1'b1;
                    w_waddr = w_ld_flat;
                    w_wdata = bus.ld_data;
                end
                if (bus.clr_req && w_clr_bank_ok) begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_cnt_nxt  = '0;
                    w_clr_bank_nxt = bus.clr_bank;
                end
            end
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = w_clr_flat;
                w_wdata = '0;
                if (r_clr_cnt == c_CW'(DEPTH - 1)) begin
                    w_state_nxt = S_READY;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_READY;
        endcase
    end

    // Storage write; reset blocks the write so an aborted clear stops cleanly.
    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Registered fetch result with stall hold; out-of-range returns "done" (0).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iptr       <= '0;
            r_iptr_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else if (!bus.stall) begin
            r_iptr_valid <= w_fetch_acc;
            if (w_fetch_acc) begin
                if (w_fetch_in_range) begin
                    r_iptr     <= w_rdata;
                    r_addr_err <= 1'b0;
                end else begin
                    r_iptr     <= '0;
                    r_addr_err <= 1'b1;
                end
            end
        end
    end

    assign bus.iptr       = r_iptr;
    assign bus.iptr_valid = r_iptr_valid;
    assign bus.addr_err   = r_addr_err;
    assign bus.busy       = (r_state == S_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_imem_banked.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_banked
//  Description : Two imem_banked instances (DEPTH 256 and 64) driven by the
//                same stimulus, each checked against its own word-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_banked;
    logic       clk;
    logic       rst;
    logic       fetch_req;
    logic [7:0] pc;
    logic [1:0] bank_sel;
    logic       stall;
    logic       ld_en;
    logic [1:0] ld_bank;
    logic [7:0] ld_addr;
    logic [8:0] ld_data;
    logic       clr_req;
    logic [1:0] clr_bank;

    int checks = 0;
    int errors = 0;

    imem_banked_if #(.IW(9), .PW(8), .BW(2)) bus0 ();
    imem_banked_if #(.IW(9), .PW(8), .BW(2)) bus1 ();

    assign bus0.fetch_req = fetch_req;  assign bus1.fetch_req = fetch_req;
    assign bus0.pc        = pc;         assign bus1.pc        = pc;
    assign bus0.bank_sel  = bank_sel;   assign bus1.bank_sel  = bank_sel;
    assign bus0.stall     = stall;      assign bus1.stall     = stall;
    assign bus0.ld_en     = ld_en;      assign bus1.ld_en     = ld_en;
    assign bus0.ld_bank   = ld_bank;    assign bus1.ld_bank   = ld_bank;
    assign bus0.ld_addr   = ld_addr;    assign bus1.ld_addr   = ld_addr;
    assign bus0.ld_data   = ld_data;    assign bus1.ld_data   = ld_data;
    assign bus0.clr_req   = clr_req;    assign bus1.clr_req   = clr_req;
    assign bus0.clr_bank  = clr_bank;   assign bus1.clr_bank  = clr_bank;

    imem_banked #(.IW(9), .PW(8), .DEPTH(256), .BANKS(4)) u_dut256 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    imem_banked #(.IW(9), .PW(8), .DEPTH(64), .BANKS(4)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    logic [8:0] d_iptr  [2];
    logic       d_valid [2];
    logic       d_err   [2];
    logic       d_busy  [2];
    assign d_iptr[0] = bus0.iptr;  assign d_valid[0] = bus0.iptr_valid;
    assign d_err[0]  = bus0.addr_err; assign d_busy[0] = bus0.busy;
    assign d_iptr[1] = bus1.iptr;  assign d_valid[1] = bus1.iptr_valid;
    assign d_err[1]  = bus1.addr_err; assign d_busy[1] = bus1.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [8:0] mmem [2][4][256];
    logic [8:0] e_iptr  [2];
    bit         e_valid [2];
    bit         e_err   [2];
    bit         m_busy  [2];
    int         m_cnt   [2];
    int         m_cb    [2];
    bit         model_live = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int k);
        int d;
        bit ready;
        d     = (k == 0) ? 256 : 64;
        ready = !m_busy[k];
        if (m_busy[k]) begin
            mmem[k][m_cb[k]][m_cnt[k]] = '0;
            if (m_cnt[k] == d - 1) m_busy[k] = 1'b0;
            else                   m_cnt[k]  = m_cnt[k] + 1;
        end else if (ld_en && int'(ld_addr) < d) begin
            mmem[k][int'(ld_bank)][int'(ld_addr)] = ld_data;
        end
        if (!stall) begin
            e_valid[k] = ready && fetch_req;
            if (ready && fetch_req) begin
                if (int'(pc) < d) begin
                    e_iptr[k] = mmem[k][int'(bank_sel)][int'(pc)];
                    e_err[k]  = 1'b0;
                end else begin
                    e_iptr[k] = '0;
                    e_err[k]  = 1'b1;
                end
            end
        end
        if (ready && clr_req) begin
            m_busy[k] = 1'b1;
            m_cb[k]   = int'(clr_bank);
            m_cnt[k]  = 0;
        end
    endtask

    // Advance the model on each rising edge from the inputs that edge sees.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                e_iptr[k]  = '0;
                e_valid[k] = 1'b0;
                e_err[k]   = 1'b0;
                m_busy[k]  = 1'b0;
                m_cnt[k]   = 0;
            end else begin
                step(k);
            end
        end
        if (rst) model_live = 1'b1;
    end

    // Compare every output of both instances mid-cycle.
    always @(negedge clk) begin
        if (model_live) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("i%0d_iptr", k),  32'(d_iptr[k]),  32'(e_iptr[k]));
                chk($sformatf("i%0d_valid", k), 32'(d_valid[k]), 32'(e_valid[k]));
                chk($sformatf("i%0d_err", k),   32'(d_err[k]),   32'(e_err[k]));
                chk($sformatf("i%0d_busy", k),  32'(d_busy[k]),  32'(m_busy[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_req = 0; pc = 0; bank_sel = 0; stall = 0;
        ld_en = 0; ld_bank = 0; ld_addr = 0; ld_data = 0;
        clr_req = 0; clr_bank = 0;
    endtask

    task automatic load(input int b, input int a, input int v);
        ld_en = 1; ld_bank = 2'(b); ld_addr = 8'(a); ld_data = 9'(v);
        tick();
        ld_en = 0;
    endtask

    task automatic fetch(input int b, input int a);
        fetch_req = 1; bank_sel = 2'(b); pc = 8'(a);
        tick();
        fetch_req = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus0.busy || bus1.busy) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still high after %0d cycles, required 0", n);
        end
    endtask

    initial begin
        int n0;
        int n1;
        for (int k = 0; k < 2; k++)
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < 256; a++)
                    mmem[k][b][a] = '0;
        rst = 1;
        idle();
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_iptr",  32'(d_iptr[k]),  32'd0);
            chk("rst_valid", 32'(d_valid[k]), 32'd0);
            chk("rst_err",   32'(d_err[k]),   32'd0);
            chk("rst_busy",  32'(d_busy[k]),  32'd0);
        end
        rst = 0;

        // Zero every bank so the storage starts from known contents.
        for (int b = 0; b < 4; b++) begin
            clr_req = 1; clr_bank = 2'(b);
            tick();
            clr_req = 0;
            wait_idle();
        end

        // Back-to-back fetches of freshly loaded words.
        for (int i = 0; i < 4; i++) load(0, i, i + 1);
        fetch_req = 1; bank_sel = 0;
        for (int i = 0; i < 4; i++) begin
            pc = 8'(i);
            tick();
            chk("seq_iptr",  32'(bus0.iptr), 32'(i + 1));
            chk("seq_valid", 32'(bus0.iptr_valid), 32'd1);
            chk("seq_err",   32'(bus0.addr_err), 32'd0);
        end
        fetch_req = 0;

        // Banks are independent.
        load(1, 5, 9'h1AB);
        load(0, 5, 9'h055);
        fetch(1, 5);
        chk("bank1_w5", 32'(bus0.iptr), 32'h1AB);
        fetch(0, 5);
        chk("bank0_w5", 32'(bus0.iptr), 32'h055);

        // Out-of-range on the 64-deep instance.
        fetch(0, 64);
        chk("oor_iptr",  32'(bus1.iptr), 32'd0);
        chk("oor_err",   32'(bus1.addr_err), 32'd1);
        chk("oor_valid", 32'(bus1.iptr_valid), 32'd1);
        load(0, 70, 9'h1FF);
        fetch(1, 6);
        chk("oor_load_alias", 32'(bus1.iptr), 32'd0);
        chk("oor_load_err",   32'(bus1.addr_err), 32'd0);

        // Stall holds the previous result.
        fetch(0, 2);
        chk("pre_stall", 32'(bus0.iptr), 32'd3);
        stall = 1; fetch_req = 1; pc = 8'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_iptr",  32'(bus0.iptr), 32'd3);
            chk("stall_valid", 32'(bus0.iptr_valid), 32'd1);
        end
        stall = 0;
        tick();
        chk("post_stall", 32'(bus0.iptr), 32'd4);
        fetch_req = 0;

        // Write-first on a simultaneous load and fetch.
        ld_en = 1; ld_bank = 2; ld_addr = 9; ld_data = 9'h0F0;
        fetch_req = 1; bank_sel = 2; pc = 9;
        tick();
        idle();
        chk("write_first", 32'(bus0.iptr), 32'h0F0);

        // Full clear of bank 0 with fetches attempted throughout.
        clr_req = 1; clr_bank = 0;
        tick();
        clr_req = 0;
        fetch_req = 1; bank_sel = 0;
        n0 = 0; n1 = 0;
        while (bus0.busy && n0 < 400) begin
            n0++;
            if (bus1.busy) n1++;
            pc = 8'($urandom_range(0, 63));
            tick();
        end
        fetch_req = 0;
        chk("clr256_cycles", 32'(n0), 32'd256);
        chk("clr64_cycles",  32'(n1), 32'd64);
        for (int i = 0; i < 4; i++) begin
            fetch(0, i);
            chk("cleared_w", 32'(bus0.iptr), 32'd0);
        end

        // Reset aborts a clear part-way.
        for (int i = 0; i <= 10; i++) load(0, i, 9'h100 + i);
        clr_req = 1; clr_bank = 0;
        tick();
        clr_req = 0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("abort_busy", 32'(bus0.busy), 32'd0);
        for (int i = 0; i <= 10; i++) fetch(0, i);
        chk("abort_w10", 32'(bus0.iptr), 32'h10A);
        fetch(0, 9);
        chk("abort_w9", 32'(bus0.iptr), 32'd0);

        // Randomised traffic checked by the model.
        for (int c = 0; c < 2000; c++) begin
            fetch_req = ($urandom_range(0, 9) < 7);
            bank_sel  = 2'($urandom);
            pc        = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 79));
            stall     = ($urandom_range(0, 4) == 0);
            ld_en     = ($urandom_range(0, 9) < 3);
            ld_bank   = 2'($urandom);
            ld_addr   = 8'($urandom_range(0, 79));
            ld_data   = 9'($urandom);
            clr_req   = ($urandom_range(0, 299) == 0);
            clr_bank  = 2'($urandom);
            tick();
        end
        idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
